// File: rtl/tetris_engine_param.sv
// Tetris placement engine: takes one piece per handshake, drops it,
// clears full rows, reports score/err/fail and the final board.
// Ports: clk, rst (sync, active high); in_valid/in_ready handshake with
// tetrominoes (shape 0..7) and position (left column); score_valid pulse
// with score/fail/err; tetris_valid pulse with the ROWS*COLS final board.
module tetris_engine_param #(
  parameter int COLS     = 6,
  parameter int ROWS     = 12,
  parameter int GAME_LEN = 16,
  parameter int SCORE_W  = 4,
  localparam int POS_W   = $clog2(COLS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           tetrominoes,
  input  logic [POS_W-1:0]     position,
  output logic                 score_valid,
  output logic [SCORE_W-1:0]   score,
  output logic                 fail,
  output logic                 err,
  output logic                 tetris_valid,
  output logic [ROWS*COLS-1:0] tetris
);

  localparam int NR    = ROWS + 4;
  localparam int CNT_W = $clog2(GAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE, PLACE, CLEAR, REPORT
  } state_t;

  state_t state_q, state_d;
  logic [NR-1:0][COLS-1:0] board_q, board_d;
  logic [2:0] shape_q, shape_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic err_q, err_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [3:0][3:0] mask;
  logic [NR-1:0][COLS-1:0] placed, shifted;
  logic bad, found, over, game_end;
  int wid, base, lo, col, pr, pc, idx;
  int hgt [COLS];

  // bit r*4+c set = cell at (row r, col c) from bounding-box bottom-left
  function automatic logic [15:0] shape_mask(input logic [2:0] s);
    unique case (s)
      3'd0: return 16'h0033;
      3'd1: return 16'h1111;
      3'd2: return 16'h000F;
      3'd3: return 16'h0322;
      3'd4: return 16'h0071;
      3'd5: return 16'h0113;
      3'd6: return 16'h0132;
      default: return 16'h0063;
    endcase
  endfunction

  function automatic int shape_width(input logic [2:0] s);
    unique case (s)
      3'd1: return 1;
      3'd2: return 4;
      3'd4, 3'd7: return 3;
      default: return 2;
    endcase
  endfunction

  // drop position and the board with the piece merged in
  always_comb begin
    mask = shape_mask(shape_q);
    wid  = shape_width(shape_q);
    bad  = (int'(pos_q) + wid) > COLS;
    for (int c = 0; c < COLS; c++) begin
      hgt[c] = 0;
      for (int r = 0; r < NR; r++)
        if (board_q[r][c]) hgt[c] = r + 1;
    end
    base = 0;
    for (int k = 0; k < 4; k++) begin
      lo = 4;
      for (int r = 3; r >= 0; r--)
        if (mask[r][k]) lo = r;
      col = int'(pos_q) + k;
      if (lo < 4 && col < COLS)
        if (hgt[col] - lo > base) base = hgt[col] - lo;
    end
    placed = board_q;
    for (int r = 0; r < NR; r++)
      for (int c = 0; c < COLS; c++) begin
        pr = r - base;
        pc = c - int'(pos_q);
        if (pr >= 0 && pr < 4 && pc >= 0 && pc < 4)
          if (mask[pr[1:0]][pc[1:0]]) placed[r][c] = 1'b1;
      end
  end

  // lowest full row and the board with it removed
  always_comb begin
    found = 1'b0;
    idx   = 0;
    for (int r = NR - 1; r >= 0; r--)
      if (&board_q[r]) begin
        found = 1'b1;
        idx   = r;
      end
    shifted = board_q;
    for (int r = 0; r < NR; r++)
      if (r >= idx)
        shifted[r] = (r < NR - 1) ? board_q[r+1] : '0;
  end

  assign over     = |board_q[NR-1:ROWS];
  assign game_end = over || (count_q == CNT_W'(GAME_LEN - 1));

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    shape_d = shape_q;
    pos_d   = pos_q;
    err_d   = err_q;
    score_d = score_q;
    count_d = count_q;
    unique case (state_q)
      IDLE: if (in_valid) begin
        shape_d = tetrominoes;
        pos_d   = position;
        state_d = PLACE;
      end
      // rejected pieces still pass through CLEAR so every
      // report lands 3+k cycles after the accept
      PLACE: begin
        err_d   = bad;
        if (!bad) board_d = placed;
        state_d = CLEAR;
      end
      CLEAR: if (found) begin
        board_d = shifted;
        if (score_q != '1) score_d = score_q + 1'b1;
      end else begin
        state_d = REPORT;
      end
      default: begin
        count_d = count_q + 1'b1;
        if (game_end) begin
          board_d = '0;
          score_d = '0;
          count_d = '0;
        end
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      board_q <= '0;
      shape_q <= '0;
      pos_q   <= '0;
      err_q   <= 1'b0;
      score_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      shape_q <= shape_d;
      pos_q   <= pos_d;
      err_q   <= err_d;
      score_q <= score_d;
      count_q <= count_d;
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign score_valid  = (state_q == REPORT);
  assign score        = score_valid ? score_q : '0;
  assign err          = score_valid & err_q;
  assign fail         = score_valid & over;
  assign tetris_valid = score_valid & game_end;
  assign tetris       = tetris_valid ? board_q[ROWS-1:0] : '0;

endmodule

// File: tb/tb_tetris_engine_param.sv
// Directed bench for tetris_engine_param: default 6x12 core plus an
// 8x10 / 2-bit-score instance for saturation and mid-clear reset.
module tb_tetris_engine_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic a_rst, a_in_valid, a_in_ready;
  logic [2:0] a_shape, a_pos;
  logic a_sv, a_fail, a_err, a_tv;
  logic [3:0] a_score;
  logic [71:0] a_tetris;

  logic b_rst, b_in_valid, b_in_ready;
  logic [2:0] b_shape, b_pos;
  logic b_sv, b_fail, b_err, b_tv;
  logic [1:0] b_score;
  logic [79:0] b_tetris;

  tetris_engine_param dut_a (
    .clk(clk), .rst(a_rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready),
    .tetrominoes(a_shape), .position(a_pos),
    .score_valid(a_sv), .score(a_score),
    .fail(a_fail), .err(a_err),
    .tetris_valid(a_tv), .tetris(a_tetris)
  );

  tetris_engine_param #(
    .COLS(8), .ROWS(10), .SCORE_W(2)
  ) dut_b (
    .clk(clk), .rst(b_rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .tetrominoes(b_shape), .position(b_pos),
    .score_valid(b_sv), .score(b_score),
    .fail(b_fail), .err(b_err),
    .tetris_valid(b_tv), .tetris(b_tetris)
  );

  bit sel = 1'b0;
  int n_chk = 0;
  int n_fail = 0;

  logic o_rdy, o_sv, o_fail, o_err, o_tv;
  logic [3:0] o_score;
  logic [127:0] o_tet;

  always_comb begin
    o_rdy   = sel ? b_in_ready : a_in_ready;
    o_sv    = sel ? b_sv : a_sv;
    o_fail  = sel ? b_fail : a_fail;
    o_err   = sel ? b_err : a_err;
    o_tv    = sel ? b_tv : a_tv;
    o_score = sel ? {2'b00, b_score} : a_score;
    o_tet   = sel ? {48'b0, b_tetris} : {56'b0, a_tetris};
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] s,
                       input logic [2:0] p);
    if (sel) begin
      b_in_valid = v; b_shape = s; b_pos = p;
    end else begin
      a_in_valid = v; a_shape = s; a_pos = p;
    end
  endtask

  task automatic idle_outs(input string tag);
    chk({tag, " rdy"}, o_rdy, 1);
    chk({tag, " sv"}, o_sv, 0);
    chk({tag, " score"}, o_score, 0);
    chk({tag, " err"}, o_err, 0);
    chk({tag, " fail"}, o_fail, 0);
    chk({tag, " tv"}, o_tv, 0);
    chk({tag, " tetris"}, o_tet, 0);
  endtask

  task automatic send(input string tag, input logic [2:0] s,
                      input logic [2:0] p, input int lat,
                      input logic [3:0] sc, input logic e,
                      input logic f, input logic tv,
                      input logic [127:0] tet, input bit noise);
    int n;
    @(negedge clk);
    chk({tag, " rdy"}, o_rdy, 1);
    drive(1'b1, s, p);
    @(posedge clk);
    #1 drive(noise, 3'd1, 3'd0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!o_sv && n < 20);
    drive(1'b0, 3'd0, 3'd0);
    chk({tag, " lat"}, n, lat);
    chk({tag, " score"}, o_score, sc);
    chk({tag, " err"}, o_err, e);
    chk({tag, " fail"}, o_fail, f);
    chk({tag, " tv"}, o_tv, tv);
    chk({tag, " tetris"}, o_tet, tet);
    chk({tag, " busy"}, o_rdy, 0);
    @(negedge clk);
    chk({tag, " sv1"}, o_sv, 0);
    chk({tag, " tv1"}, o_tv, 0);
    chk({tag, " rdy1"}, o_rdy, 1);
  endtask

  logic [127:0] ftet;
  int exp_sc;

  initial begin
    a_rst = 1'b1; b_rst = 1'b1;
    a_in_valid = 0; a_shape = 0; a_pos = 0;
    b_in_valid = 0; b_shape = 0; b_pos = 0;

    // reset
    @(posedge clk);
    @(negedge clk);
    sel = 0; idle_outs("rst_a");
    sel = 1; idle_outs("rst_b");
    @(negedge clk);
    a_rst = 1'b0; b_rst = 1'b0;
    @(negedge clk);
    sel = 0; chk("rel_a rdy", o_rdy, 1);
    sel = 1; chk("rel_b rdy", o_rdy, 1);

    // game A: single clear, err, then column-0 tower overflow
    sel = 0;
    send("a1", 3'd2, 3'd0, 3, 0, 0, 0, 0, 0, 0);
    send("a2", 3'd0, 3'd4, 4, 1, 0, 0, 0, 0, 1);
    send("a3err", 3'd2, 3'd3, 3, 1, 1, 0, 0, 0, 0);
    send("a4", 3'd1, 3'd0, 3, 1, 0, 0, 0, 0, 1);
    send("a5", 3'd1, 3'd0, 3, 1, 0, 0, 0, 0, 0);
    send("a6", 3'd1, 3'd0, 3, 1, 0, 0, 0, 0, 0);
    ftet = '0;
    ftet[5:0] = 6'h31;
    for (int r = 1; r < 12; r++) ftet[r*6] = 1'b1;
    send("a7fail", 3'd1, 3'd0, 3, 1, 0, 1, 1, ftet, 0);

    // game B: 16 pieces, two rows cleared every third piece
    for (int c = 0; c < 5; c++) begin
      send("b_p0", 3'd0, 3'd0, 3, 4'(2*c), 0, 0, 0, 0, c[0]);
      send("b_p2", 3'd0, 3'd2, 3, 4'(2*c), 0, 0, 0, 0, 0);
      send("b_p4", 3'd0, 3'd4, 5, 4'(2*c+2), 0, 0, 0, 0, 1);
    end
    ftet = 128'h0C3;
    send("b_last", 3'd0, 3'd0, 3, 10, 0, 0, 1, ftet, 0);

    // 8-wide board, 2-bit score saturation
    sel = 1;
    for (int i = 1; i <= 5; i++) begin
      exp_sc = (i - 1 > 3) ? 3 : i - 1;
      send("s_l", 3'd2, 3'd0, 3, 4'(exp_sc), 0, 0, 0, 0, 0);
      exp_sc = (i > 3) ? 3 : i;
      send("s_r", 3'd2, 3'd4, 4, 4'(exp_sc), 0, 0, 0, 0, 0);
    end

    // reset while clearing a row
    send("m_l", 3'd2, 3'd0, 3, 3, 0, 0, 0, 0, 0);
    @(negedge clk);
    drive(1'b1, 3'd2, 3'd4);
    @(posedge clk);
    #1 drive(1'b0, 3'd0, 3'd0);
    @(negedge clk);
    @(negedge clk);
    chk("m_clear busy", o_rdy, 0);
    b_rst = 1'b1;
    @(negedge clk);
    idle_outs("m_rst");
    b_rst = 1'b0;
    send("m_after_l", 3'd2, 3'd0, 3, 0, 0, 0, 0, 0, 0);
    send("m_after_r", 3'd2, 3'd4, 4, 1, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
